// File: rtl/shm_seq.sv
// shm_seq: multi-cycle 72-bit AR!ARX shifter (logical/rotate/arithmetic), up to 36 places per step.
// Define SHM_SEQ_ARITH_EN to enable arithmetic mode and the SHM_OV flag; otherwise mode 10 is logical.
module shm_seq (
    input  logic        eboxClk,
    input  logic        eboxReset_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [0:35] EDP_AR,
    input  logic [0:35] EDP_ARX,
    input  logic [0:9]  SCD_SC,
    output logic        busy,
    output logic        done,
    output logic [0:35] SHM_AR,
    output logic [0:35] SHM_ARX,
    output logic        SHM_OV
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t       state, state_nx;
    logic [71:0]  word, word_nx;
    logic [1:0]   mode_q, mode_nx;
    logic         dir_q, dir_nx;
    logic [10:0]  remaining, remaining_nx;
    logic         ov, ov_nx;

    logic [10:0]  sc_ext;
    logic [10:0]  sc_abs;
    logic [5:0]   k;
    logic         arith;
    logic         rotate;
    logic [143:0] rot_l;
    logic [143:0] rot_r;
    logic [70:0]  out_mask;
    logic [71:0]  shifted;
    logic         ov_step;

`ifdef SHM_SEQ_ARITH_EN
    assign arith = (mode_q == 2'b10);
`else
    assign arith = 1'b0;
`endif
    assign rotate = (mode_q == 2'b01);

    // Bit 0 of SC is the sign; 11-bit magnitude so that -512 yields 512.
    assign sc_ext = {SCD_SC[0], SCD_SC};
    assign sc_abs = sc_ext[10] ? (~sc_ext + 11'd1) : sc_ext;

    always_comb begin
        k        = (remaining > 11'd36) ? 6'd36 : remaining[5:0];
        rot_l    = {word, word} << k;
        rot_r    = {word, word} >> k;
        out_mask = ~({71{1'b1}} >> k);
        ov_step  = 1'b0;
        shifted  = dir_q ? (word >> k) : (word << k);
        if (rotate) begin
            shifted = dir_q ? rot_r[71:0] : rot_l[143:72];
        end else if (arith) begin
            if (dir_q) begin
                shifted = $signed(word) >>> k;
            end else begin
                // Sign bit held; the top k magnitude bits leave through AR[1].
                shifted = {word[71], word[70:0] << k};
                ov_step = |((word[70:0] ^ {71{word[71]}}) & out_mask);
            end
        end
    end

    always_comb begin
        state_nx     = state;
        word_nx      = word;
        mode_nx      = mode_q;
        dir_nx       = dir_q;
        remaining_nx = remaining;
        ov_nx        = ov;
        case (state)
            IDLE: begin
                if (start) begin
                    word_nx      = {EDP_AR, EDP_ARX};
                    mode_nx      = mode;
                    dir_nx       = SCD_SC[0];
                    remaining_nx = sc_abs;
                    ov_nx        = 1'b0;
                    state_nx     = (sc_abs == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                word_nx      = shifted;
                remaining_nx = remaining - {5'd0, k};
                ov_nx        = ov | ov_step;
                if (remaining == {5'd0, k}) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            state     <= IDLE;
            word      <= '0;
            mode_q    <= '0;
            dir_q     <= 1'b0;
            remaining <= '0;
            ov        <= 1'b0;
        end else begin
            state     <= state_nx;
            word      <= word_nx;
            mode_q    <= mode_nx;
            dir_q     <= dir_nx;
            remaining <= remaining_nx;
            ov        <= ov_nx;
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign SHM_AR  = word[71:36];
    assign SHM_ARX = word[35:0];
    assign SHM_OV  = ov;

endmodule

// File: tb/tb_shm_seq.sv
// Directed self-checking bench for shm_seq; arithmetic expectations follow SHM_SEQ_ARITH_EN.
module tb_shm_seq;

    logic        eboxClk = 1'b0;
    logic        eboxReset_n;
    logic        start;
    logic [1:0]  mode;
    logic [0:35] EDP_AR;
    logic [0:35] EDP_ARX;
    logic [0:9]  SCD_SC;
    logic        busy;
    logic        done;
    logic [0:35] SHM_AR;
    logic [0:35] SHM_ARX;
    logic        SHM_OV;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 eboxClk = ~eboxClk;

    shm_seq dut (
        .eboxClk    (eboxClk),
        .eboxReset_n(eboxReset_n),
        .start      (start),
        .mode       (mode),
        .EDP_AR     (EDP_AR),
        .EDP_ARX    (EDP_ARX),
        .SCD_SC     (SCD_SC),
        .busy       (busy),
        .done       (done),
        .SHM_AR     (SHM_AR),
        .SHM_ARX    (SHM_ARX),
        .SHM_OV     (SHM_OV)
    );

    // Runs one operation: cyc = edges after the start edge until done (40 = timed out).
    task automatic run_op(input logic [1:0] m, input logic [35:0] ar, input logic [35:0] arx,
                          input logic [9:0] sc, output int cyc, output logic [35:0] rar,
                          output logic [35:0] rarx, output logic rov, output logic busy0,
                          output logic busy_after);
        @(negedge eboxClk);
        mode = m; EDP_AR = ar; EDP_ARX = arx; SCD_SC = sc; start = 1'b1;
        @(posedge eboxClk); #1;
        start = 1'b0;
        busy0 = busy;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge eboxClk); #1;
            cyc++;
        end
        rar = SHM_AR; rarx = SHM_ARX; rov = SHM_OV;
        @(posedge eboxClk); #1;
        busy_after = busy;
    endtask

    task automatic test_reset;
        eboxReset_n = 1'b0; start = 1'b0; mode = 2'b00;
        EDP_AR = '1; EDP_ARX = '1; SCD_SC = 10'd5;
        repeat (2) @(posedge eboxClk);
        #1;
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++;
            $display("FAIL reset_ctl: busy=%b done=%b want 0 0", busy, done); end
        vectors++; if (SHM_AR !== 36'o0 || SHM_ARX !== 36'o0 || SHM_OV !== 1'b0) begin miscompares++;
            $display("FAIL reset_data: ar=%o arx=%o ov=%b want 0 0 0", SHM_AR, SHM_ARX, SHM_OV); end
        @(negedge eboxClk);
        eboxReset_n = 1'b1;
    endtask

    task automatic test_logical;
        int cyc; logic [35:0] ar, arx; logic ov, b0, ba;
        run_op(2'b00, 36'o0, 36'o400000000000, 10'd1, cyc, ar, arx, ov, b0, ba);
        vectors++; if (ar !== 36'o000000000001 || arx !== 36'o0) begin miscompares++;
            $display("FAIL lsh1_data: ar=%o arx=%o want 000000000001 0", ar, arx); end
        vectors++; if (cyc !== 1 || b0 !== 1'b1 || ba !== 1'b0) begin miscompares++;
            $display("FAIL lsh1_timing: steps=%0d busy0=%b busy_after=%b want 1 1 0", cyc, b0, ba); end
        run_op(2'b00, 36'o0, 36'o1, 10'd100, cyc, ar, arx, ov, b0, ba);
        vectors++; if (ar !== 36'o0 || arx !== 36'o0) begin miscompares++;
            $display("FAIL lsh100_data: ar=%o arx=%o want 0 0", ar, arx); end
        vectors++; if (cyc !== 3 || b0 !== 1'b1 || ba !== 1'b0) begin miscompares++;
            $display("FAIL lsh100_timing: steps=%0d busy0=%b busy_after=%b want 3 1 0", cyc, b0, ba); end
        run_op(2'b11, 36'o777777777777, 36'o0, 10'o1734, cyc, ar, arx, ov, b0, ba);
        vectors++; if (ar !== 36'o0 || arx !== 36'o777777777777 || cyc !== 1) begin miscompares++;
            $display("FAIL rsh36: ar=%o arx=%o steps=%0d want 0 777777777777 1", ar, arx, cyc); end
    endtask

    task automatic test_rotate;
        int cyc; logic [35:0] ar, arx; logic ov, b0, ba;
        run_op(2'b01, 36'o0, 36'o1, 10'o1777, cyc, ar, arx, ov, b0, ba);
        vectors++; if (ar !== 36'o400000000000 || arx !== 36'o0 || cyc !== 1) begin miscompares++;
            $display("FAIL rotr1: ar=%o arx=%o steps=%0d want 400000000000 0 1", ar, arx, cyc); end
        run_op(2'b01, 36'o123456701234, 36'o765432107654, 10'd72, cyc, ar, arx, ov, b0, ba);
        vectors++; if (ar !== 36'o123456701234 || arx !== 36'o765432107654 || cyc !== 2) begin miscompares++;
            $display("FAIL rotl72: ar=%o arx=%o steps=%0d want 123456701234 765432107654 2", ar, arx, cyc); end
        run_op(2'b01, 36'o1, 36'o0, 10'd40, cyc, ar, arx, ov, b0, ba);
        vectors++; if (ar !== 36'o0 || arx !== 36'o20 || cyc !== 2) begin miscompares++;
            $display("FAIL rotl40: ar=%o arx=%o steps=%0d want 0 20 2", ar, arx, cyc); end
        run_op(2'b01, 36'o0, 36'o1, 10'o1000, cyc, ar, arx, ov, b0, ba);
        vectors++; if (ar !== 36'o002000000000 || arx !== 36'o0) begin miscompares++;
            $display("FAIL rotr512_data: ar=%o arx=%o want 002000000000 0", ar, arx); end
        vectors++; if (cyc !== 15 || ba !== 1'b0) begin miscompares++;
            $display("FAIL rotr512_steps: steps=%0d busy_after=%b want 15 0", cyc, ba); end
    endtask

    task automatic test_arith;
        int cyc; logic [35:0] ar, arx; logic ov, b0, ba;
        logic [35:0] exp_ar;
        logic exp_ov;
        run_op(2'b10, 36'o400000000000, 36'o0, 10'o1775, cyc, ar, arx, ov, b0, ba);
`ifdef SHM_SEQ_ARITH_EN
        exp_ar = 36'o740000000000;
`else
        exp_ar = 36'o040000000000;
`endif
        vectors++; if (ar !== exp_ar || arx !== 36'o0 || ov !== 1'b0 || cyc !== 1) begin miscompares++;
            $display("FAIL ash_r3: ar=%o arx=%o ov=%b steps=%0d want %o 0 0 1", ar, arx, ov, cyc, exp_ar); end
        run_op(2'b10, 36'o200000000000, 36'o0, 10'd1, cyc, ar, arx, ov, b0, ba);
`ifdef SHM_SEQ_ARITH_EN
        exp_ar = 36'o0; exp_ov = 1'b1;
`else
        exp_ar = 36'o400000000000; exp_ov = 1'b0;
`endif
        vectors++; if (ar !== exp_ar || arx !== 36'o0 || ov !== exp_ov) begin miscompares++;
            $display("FAIL ash_l1: ar=%o arx=%o ov=%b want %o 0 %b", ar, arx, ov, exp_ar, exp_ov); end
        vectors++; if (SHM_OV !== exp_ov || SHM_AR !== exp_ar) begin miscompares++;
            $display("FAIL ash_hold: ar=%o ov=%b want %o %b", SHM_AR, SHM_OV, exp_ar, exp_ov); end
    endtask

    task automatic test_zero_count;
        int cyc; logic [35:0] ar, arx; logic ov, b0, ba;
        run_op(2'b00, 36'o123123123123, 36'o456456456456, 10'd0, cyc, ar, arx, ov, b0, ba);
        vectors++; if (ar !== 36'o123123123123 || arx !== 36'o456456456456) begin miscompares++;
            $display("FAIL sc0_data: ar=%o arx=%o want 123123123123 456456456456", ar, arx); end
        vectors++; if (cyc !== 0 || b0 !== 1'b1 || ba !== 1'b0) begin miscompares++;
            $display("FAIL sc0_timing: steps=%0d busy0=%b busy_after=%b want 0 1 0", cyc, b0, ba); end
    endtask

    task automatic test_start_ignored;
        @(negedge eboxClk);
        mode = 2'b00; EDP_AR = 36'o0; EDP_ARX = 36'o1; SCD_SC = 10'd100; start = 1'b1;
        @(posedge eboxClk); #1;
        EDP_AR = '1; EDP_ARX = '1; SCD_SC = 10'o1777; mode = 2'b01;
        @(posedge eboxClk); #1;
        @(posedge eboxClk); #1;
        start = 1'b0;
        @(posedge eboxClk); #1;
        vectors++; if (done !== 1'b1 || SHM_AR !== 36'o0 || SHM_ARX !== 36'o0) begin miscompares++;
            $display("FAIL busy_start: done=%b ar=%o arx=%o want 1 0 0", done, SHM_AR, SHM_ARX); end
        start = 1'b1;
        @(posedge eboxClk); #1;
        start = 1'b0;
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++;
            $display("FAIL done_start: busy=%b done=%b want 0 0", busy, done); end
        @(posedge eboxClk); #1;
        vectors++; if (busy !== 1'b0 || SHM_AR !== 36'o0 || SHM_ARX !== 36'o0) begin miscompares++;
            $display("FAIL done_start_hold: busy=%b ar=%o arx=%o want 0 0 0", busy, SHM_AR, SHM_ARX); end
    endtask

    task automatic test_reset_mid;
        int cyc; logic [35:0] ar, arx; logic ov, b0, ba;
        @(negedge eboxClk);
        mode = 2'b01; EDP_AR = '1; EDP_ARX = '1; SCD_SC = 10'o1000; start = 1'b1;
        @(posedge eboxClk); #1;
        start = 1'b0;
        repeat (3) @(posedge eboxClk);
        #1;
        eboxReset_n = 1'b0;
        #1;
        vectors++; if (SHM_AR !== 36'o0 || SHM_ARX !== 36'o0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: ar=%o arx=%o busy=%b done=%b want 0 0 0 0", SHM_AR, SHM_ARX, busy, done); end
        repeat (2) @(posedge eboxClk);
        @(negedge eboxClk);
        eboxReset_n = 1'b1;
        run_op(2'b00, 36'o0, 36'o400000000000, 10'd1, cyc, ar, arx, ov, b0, ba);
        vectors++; if (ar !== 36'o1 || arx !== 36'o0 || cyc !== 1) begin miscompares++;
            $display("FAIL post_reset: ar=%o arx=%o steps=%0d want 1 0 1", ar, arx, cyc); end
    endtask

    task automatic test_back_to_back;
        int cyc; logic [35:0] ar, arx; logic ov, b0, ba;
        run_op(2'b01, 36'o0, 36'o1, 10'o1777, cyc, ar, arx, ov, b0, ba);
        run_op(2'b00, 36'o000000000007, 36'o0, 10'd3, cyc, ar, arx, ov, b0, ba);
        vectors++; if (ar !== 36'o000000000070 || arx !== 36'o0 || cyc !== 1) begin miscompares++;
            $display("FAIL b2b: ar=%o arx=%o steps=%0d want 70 0 1", ar, arx, cyc); end
    endtask

    initial begin
        test_reset();
        test_logical();
        test_rotate();
        test_arith();
        test_zero_count();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
